// File: rtl/systolic_result_collector.sv
// Output-side deskew and row buffer for the 5x5 weight-stationary systolic array.
// Skewed column results are realigned into rows and queued in a small FIFO drained over valid/ready.
module systolic_result_collector #(
    parameter int NCOL       = 5,
    parameter int DW         = 16,
    parameter int SKEW       = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 ena,
    input  logic                 col_valid,
    input  logic [DW-1:0]        data_in1,
    input  logic [DW-1:0]        data_in2,
    input  logic [DW-1:0]        data_in3,
    input  logic [DW-1:0]        data_in4,
    input  logic [DW-1:0]        data_in5,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [NCOL*DW-1:0]   out_row,
    output logic [2:0]           fifo_level,
    output logic [7:0]           row_count,
    output logic                 overflow
);

    localparam int VD = (NCOL - 1) * SKEW;
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DW-1:0]      lane_in [NCOL];
    logic [NCOL*DW-1:0] aligned_row;
    logic [VD-1:0]      valid_pipe;
    logic               aligned_valid;

    assign lane_in[0] = data_in1;
    assign lane_in[1] = data_in2;
    assign lane_in[2] = data_in3;
    assign lane_in[3] = data_in4;
    assign lane_in[4] = data_in5;

    // Earlier columns wait longer so every lane of a row lines up with the last column.
    for (genvar k = 0; k < NCOL; k++) begin : g_lane
        localparam int D = (NCOL - 1 - k) * SKEW;
        if (D == 0) begin : g_direct
            assign aligned_row[k*DW +: DW] = lane_in[k];
        end else begin : g_dly
            logic [DW-1:0] dly [D];
            always_ff @(posedge clk or negedge clear_n) begin
                if (!clear_n) begin
                    for (int i = 0; i < D; i++) dly[i] <= '0;
                end else if (ena) begin
                    dly[0] <= lane_in[k];
                    for (int i = 1; i < D; i++) dly[i] <= dly[i-1];
                end
            end
            assign aligned_row[k*DW +: DW] = dly[D-1];
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            valid_pipe <= '0;
        end else if (ena) begin
            valid_pipe <= {valid_pipe[VD-2:0], col_valid};
        end
    end

    assign aligned_valid = valid_pipe[VD-1];

    logic [NCOL*DW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [2:0]         level;
    logic               push;
    logic               pop;
    logic               full;
    logic               wr_en;

    assign push  = ena & aligned_valid;
    assign pop   = out_valid & out_ready;
    assign full  = (level == 3'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot the push needs, so full only blocks a lone push.
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            row_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= aligned_row;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                row_count <= row_count + 8'd1;
            end
            level <= level + 3'(wr_en) - 3'(pop);
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_valid  = (level != 3'd0);
    assign out_row    = out_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector: deskew latency, streaming, backpressure,
// overflow, full push/pop, reset mid-traffic and input-side stall.
module tb_systolic_result_collector;

    logic        clk = 1'b0;
    logic        clear_n = 1'b1;
    logic        ena;
    logic        col_valid;
    logic [15:0] data_in1, data_in2, data_in3, data_in4, data_in5;
    logic        out_ready;
    logic        out_valid;
    logic [79:0] out_row;
    logic [2:0]  fifo_level;
    logic [7:0]  row_count;
    logic        overflow;

    int n_err = 0;
    int n_chk = 0;
    int rc_exp = 0;

    systolic_result_collector dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .ena        (ena),
        .col_valid  (col_valid),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .data_in3   (data_in3),
        .data_in4   (data_in4),
        .data_in5   (data_in5),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_row    (out_row),
        .fifo_level (fifo_level),
        .row_count  (row_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lane_val(input int b, input int r, input int k);
        return 16'(((b + r) << 4) | k);
    endfunction

    function automatic logic [79:0] row_val(input int b, input int r);
        logic [79:0] res;
        res = '0;
        for (int k = 0; k < 5; k++) res[k*16 +: 16] = lane_val(b, r, k);
        return res;
    endfunction

    task automatic set_lanes(input logic [15:0] d [5]);
        data_in1 = d[0];
        data_in2 = d[1];
        data_in3 = d[2];
        data_in4 = d[3];
        data_in5 = d[4];
    endtask

    // Cycle c of a skewed stream of n rows: column k carries row c-k.
    task automatic drive_stream(input int b, input int c, input int n);
        logic [15:0] d [5];
        for (int k = 0; k < 5; k++) begin
            d[k] = ((c - k) >= 0 && (c - k) < n) ? lane_val(b, c - k, k) : 16'hDEAD;
        end
        col_valid = (c >= 0 && c < n);
        set_lanes(d);
    endtask

    task automatic drive_idle;
        logic [15:0] d [5];
        for (int k = 0; k < 5; k++) d[k] = 16'h0000;
        col_valid = 1'b0;
        set_lanes(d);
    endtask

    initial begin
        ena       = 1'b1;
        out_ready = 1'b0;
        drive_idle();
        #2 clear_n = 1'b0;
        tick();
        tick();

        chk("rst_valid", 80'(out_valid), 80'(0));
        chk("rst_level", 80'(fifo_level), 80'(0));
        chk("rst_count", 80'(row_count), 80'(0));
        chk("rst_ovf",   80'(overflow), 80'(0));
        chk("rst_row",   out_row, 80'(0));
        clear_n = 1'b1;
        tick();

        // Single row, 5-cycle latency
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            logic [15:0] d [5];
            for (int k = 0; k < 5; k++) d[k] = (c == k) ? 16'(16'h11 * (k + 1)) : 16'hDEAD;
            col_valid = (c == 0);
            set_lanes(d);
            if (c == 4) chk("single_early", 80'(out_valid), 80'(0));
            tick();
        end
        drive_idle();
        chk("single_valid", 80'(out_valid), 80'(1));
        chk("single_row", out_row, 80'h0055_0044_0033_0022_0011);
        tick();
        rc_exp = 1;
        chk("single_count", 80'(row_count), 80'(rc_exp));
        chk("single_empty", 80'(out_valid), 80'(0));

        // Streaming 8 rows back to back
        for (int c = 0; c < 13; c++) begin
            drive_stream(1, c, 8);
            if (c >= 5) begin
                chk("stream_valid", 80'(out_valid), 80'(1));
                chk("stream_row", out_row, row_val(1, c - 5));
            end
            tick();
        end
        drive_idle();
        rc_exp += 8;
        chk("stream_done", 80'(out_valid), 80'(0));
        chk("stream_ovf", 80'(overflow), 80'(0));
        chk("stream_count", 80'(row_count), 80'(rc_exp));

        // Backpressure: 5 rows into a 4-deep FIFO
        out_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            drive_stream(32, c, 5);
            tick();
        end
        drive_idle();
        chk("bp_level", 80'(fifo_level), 80'(4));
        chk("bp_ovf", 80'(overflow), 80'(1));
        chk("bp_head", out_row, row_val(32, 0));
        tick();
        chk("bp_hold", out_row, row_val(32, 0));
        chk("bp_hold_valid", 80'(out_valid), 80'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain", out_row, row_val(32, i));
            tick();
        end
        rc_exp += 4;
        chk("bp_lost", 80'(out_valid), 80'(0));
        chk("bp_count", 80'(row_count), 80'(rc_exp));
        chk("bp_ovf_sticky", 80'(overflow), 80'(1));

        // Reset mid-traffic: 2 rows queued, a third in flight
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive_stream(48, c, 3);
            tick();
        end
        chk("pre_rst_level", 80'(fifo_level), 80'(2));
        clear_n = 1'b0;
        tick();
        chk("mid_rst_valid", 80'(out_valid), 80'(0));
        chk("mid_rst_level", 80'(fifo_level), 80'(0));
        chk("mid_rst_ovf", 80'(overflow), 80'(0));
        chk("mid_rst_count", 80'(row_count), 80'(0));
        chk("mid_rst_row", out_row, 80'(0));
        drive_idle();
        clear_n = 1'b1;
        rc_exp = 0;
        repeat (6) tick();
        chk("post_rst_level", 80'(fifo_level), 80'(0));

        // Full FIFO with push and pop in the same cycle
        for (int c = 0; c < 9; c++) begin
            drive_stream(64, c, 5);
            out_ready = (c == 8);
            if (c == 8) begin
                chk("full_level", 80'(fifo_level), 80'(4));
                chk("full_head", out_row, row_val(64, 0));
            end
            tick();
        end
        drive_idle();
        rc_exp += 1;
        chk("pp_level", 80'(fifo_level), 80'(4));
        chk("pp_ovf", 80'(overflow), 80'(0));
        for (int i = 1; i < 5; i++) begin
            chk("pp_drain", out_row, row_val(64, i));
            tick();
        end
        rc_exp += 4;
        chk("pp_empty", 80'(fifo_level), 80'(0));
        chk("pp_count", 80'(row_count), 80'(rc_exp));

        // ena=0 for 3 cycles after column 2, with a row already queued
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive_stream(80, c, 1);
            tick();
        end
        drive_idle();
        chk("stall_pre_level", 80'(fifo_level), 80'(1));
        for (int c = 0; c < 9; c++) begin
            ena = !(c >= 2 && c <= 4);
            out_ready = (c >= 2);
            if (ena) begin
                drive_stream(96, (c < 2) ? c : c - 3, 1);
            end else begin
                logic [15:0] d [5];
                for (int k = 0; k < 5; k++) d[k] = 16'hBAD0;
                col_valid = 1'b1;
                set_lanes(d);
            end
            if (c == 2) begin
                chk("stall_pop_valid", 80'(out_valid), 80'(1));
                chk("stall_pop_row", out_row, row_val(80, 0));
            end
            if (c == 3) begin
                rc_exp += 1;
                chk("stall_popped", 80'(fifo_level), 80'(0));
                chk("stall_pop_count", 80'(row_count), 80'(rc_exp));
            end
            if (c == 7) chk("stall_not_early", 80'(out_valid), 80'(0));
            if (c == 8) begin
                chk("stall_valid", 80'(out_valid), 80'(1));
                chk("stall_row", out_row, row_val(96, 0));
            end
            tick();
        end
        drive_idle();
        ena = 1'b1;
        rc_exp += 1;
        chk("stall_count", 80'(row_count), 80'(rc_exp));
        chk("stall_ovf", 80'(overflow), 80'(0));
        chk("stall_empty", 80'(out_valid), 80'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
